// File: rtl/servo_pkg.sv
// Shared types and helpers for the servo slew sequencer.
// Channel state encoding, duty limits and counter sizing.
package servo_pkg;

  typedef enum logic [1:0] {
    ST_HOLD  = 2'd0,
    ST_UP    = 2'd1,
    ST_DOWN  = 2'd2,
    ST_SWEEP = 2'd3
  } ch_state_e;

  localparam int DUTY_MIN_DEF = 32;
  localparam int DUTY_MAX_DEF = 64;

  // Bits needed to count 0 .. v-1.
  function automatic int clog2(
    input longint unsigned v
  );
    int r;
    longint unsigned x;
    r = 0;
    x = v - 64'd1;
    while (x > 64'd0) begin
      r = r + 1;
      x = x >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/servo_step_timer.sv
// Free-running step timer: one-cycle tick every STEP_CYCLES clocks.
// Counter restarts from zero on synchronous reset.
module servo_step_timer
  import servo_pkg::*;
#(
  parameter longint unsigned STEP_CYCLES = 20
) (
  input  logic clk,
  input  logic rst,
  output logic step_tick
);

  localparam int CW = clog2(STEP_CYCLES);
  localparam logic [CW-1:0] LAST =
    CW'(STEP_CYCLES - 64'd1);

  if (STEP_CYCLES < 2) begin : g_bad_cycles
    $error("servo_step_timer: STEP_CYCLES < 2");
  end

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign step_tick = (cnt_q == LAST);
  assign cnt_d = step_tick ? '0
                           : cnt_q + CW'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/servo_slew_sequencer.sv
// Multi-channel servo duty scheduler with slew-limited ramps
// and sawtooth sweep; sole owner of the per-channel duty words.
module servo_slew_sequencer
  import servo_pkg::*;
#(
  parameter int CLK_FREQ_HZ   = 12000000,
  parameter int PWM_PERIOD_US = 20000,
  parameter int STEP_PERIODS  = 10,
  parameter int NUM_CH        = 4,
  parameter int DUTY_MIN      = DUTY_MIN_DEF,
  parameter int DUTY_MAX      = DUTY_MAX_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [2:0]            cmd_ch,
  input  logic                  cmd_sweep,
  input  logic [7:0]            cmd_duty,
  output logic [8*NUM_CH-1:0]   duty_out,
  output logic [NUM_CH-1:0]     busy,
  output logic [NUM_CH-1:0]     done
);

  // 64-bit product: the default clock/period overflow 32 bits.
  localparam longint unsigned STEP_CYCLES =
    64'(STEP_PERIODS) * 64'(PWM_PERIOD_US)
    * 64'(CLK_FREQ_HZ) / 64'd1000000;

  localparam logic [7:0] DMIN = 8'(DUTY_MIN);
  localparam logic [7:0] DMAX = 8'(DUTY_MAX);

  if (NUM_CH < 1 || NUM_CH > 8) begin : g_bad_ch
    $error("servo_slew_sequencer: NUM_CH out of 1..8");
  end

  if (DUTY_MIN > DUTY_MAX) begin : g_bad_lim
    $error("servo_slew_sequencer: DUTY_MIN > DUTY_MAX");
  end

  logic step_tick;

  servo_step_timer #(
    .STEP_CYCLES(STEP_CYCLES)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .step_tick(step_tick)
  );

  logic ready_q;
  logic accept;
  logic [7:0] tgt_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      ready_q <= 1'b0;
    end else begin
      ready_q <= 1'b1;
    end
  end

  assign cmd_ready = ready_q;
  assign accept    = cmd_valid & ready_q;

  always_comb begin
    tgt_d = cmd_duty;
    if (cmd_duty < DMIN) begin
      tgt_d = DMIN;
    end else if (cmd_duty > DMAX) begin
      tgt_d = DMAX;
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic       sel;
    ch_state_e  st_q;
    logic [7:0] duty_q;
    logic [7:0] tgt_q;
    logic       busy_q;
    logic       done_q;
    logic [7:0] dup;
    logic [7:0] ddn;

    assign sel = accept && (cmd_ch == 3'(i));
    assign dup = duty_q + 8'd1;
    assign ddn = duty_q - 8'd1;

    // A command on this channel pre-empts the step tick.
    always_ff @(posedge clk) begin
      if (rst) begin
        st_q   <= ST_HOLD;
        duty_q <= DMIN;
        tgt_q  <= DMIN;
        busy_q <= 1'b0;
        done_q <= 1'b0;
      end else begin
        done_q <= 1'b0;
        if (sel) begin
          tgt_q <= tgt_d;
          if (cmd_sweep) begin
            st_q   <= ST_SWEEP;
            busy_q <= 1'b1;
          end else if (tgt_d > duty_q) begin
            st_q   <= ST_UP;
            busy_q <= 1'b1;
          end else if (tgt_d < duty_q) begin
            st_q   <= ST_DOWN;
            busy_q <= 1'b1;
          end else begin
            st_q   <= ST_HOLD;
            busy_q <= 1'b0;
            done_q <= 1'b1;
          end
        end else if (step_tick) begin
          unique case (st_q)
            ST_UP: begin
              duty_q <= dup;
              if (dup == tgt_q) begin
                st_q   <= ST_HOLD;
                busy_q <= 1'b0;
                done_q <= 1'b1;
              end
            end
            ST_DOWN: begin
              duty_q <= ddn;
              if (ddn == tgt_q) begin
                st_q   <= ST_HOLD;
                busy_q <= 1'b0;
                done_q <= 1'b1;
              end
            end
            ST_SWEEP: begin
              duty_q <= (duty_q >= DMAX) ? DMIN : dup;
            end
            default: begin
            end
          endcase
        end
      end
    end

    assign duty_out[8*i +: 8] = duty_q;
    assign busy[i] = busy_q;
    assign done[i] = done_q;
  end

endmodule

// File: tb/tb_servo_slew_sequencer.sv
// Bench for servo_slew_sequencer: table vectors, directed corner
// sequences and random commands against a per-cycle reference model.
module tb_servo_slew_sequencer;

  localparam int NCH  = 4;
  localparam int STEP = 20;
  localparam int DMIN = 32;
  localparam int DMAX = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cmd_valid = 1'b0;
  logic cmd_sweep = 1'b0;
  logic [2:0] cmd_ch = 3'd0;
  logic [7:0] cmd_duty = 8'd0;
  logic cmd_ready;
  logic [8*NCH-1:0] duty_out;
  logic [NCH-1:0] busy;
  logic [NCH-1:0] done;

  always #5 clk = ~clk;

  servo_slew_sequencer #(
    .CLK_FREQ_HZ  (1000000),
    .PWM_PERIOD_US(10),
    .STEP_PERIODS (2),
    .NUM_CH       (NCH),
    .DUTY_MIN     (DMIN),
    .DUTY_MAX     (DMAX)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_ch   (cmd_ch),
    .cmd_sweep(cmd_sweep),
    .cmd_duty (cmd_duty),
    .duty_out (duty_out),
    .busy     (busy),
    .done     (done)
  );

  int vectors = 0;
  int miscompares = 0;

  // Reference model: each channel moves toward its goal or sweeps.
  int m_cnt = 0;
  int m_ticks = 0;
  bit m_ready = 0;
  int m_duty[NCH];
  int m_tgt[NCH];
  bit m_sweep[NCH];
  bit m_move[NCH];
  bit m_done[NCH];

  function automatic void model_reset();
    m_cnt = 0;
    m_ready = 0;
    for (int c = 0; c < NCH; c++) begin
      m_duty[c] = DMIN;
      m_tgt[c] = DMIN;
      m_sweep[c] = 0;
      m_move[c] = 0;
      m_done[c] = 0;
    end
  endfunction

  function automatic void model_edge();
    bit tick;
    bit acc;
    int t;
    if (rst) begin
      model_reset();
      return;
    end
    tick = (m_cnt == STEP - 1);
    m_cnt = tick ? 0 : m_cnt + 1;
    if (tick) m_ticks++;
    acc = cmd_valid && m_ready;
    m_ready = 1;
    t = int'(cmd_duty);
    if (t < DMIN) t = DMIN;
    if (t > DMAX) t = DMAX;
    for (int c = 0; c < NCH; c++) begin
      m_done[c] = 0;
      if (acc && int'(cmd_ch) == c) begin
        m_tgt[c] = t;
        m_sweep[c] = cmd_sweep;
        m_move[c] = !cmd_sweep && (t != m_duty[c]);
        m_done[c] = !cmd_sweep && (t == m_duty[c]);
      end else if (tick && m_sweep[c]) begin
        m_duty[c] = (m_duty[c] == DMAX) ? DMIN : m_duty[c] + 1;
      end else if (tick && m_move[c]) begin
        m_duty[c] += (m_tgt[c] > m_duty[c]) ? 1 : -1;
        if (m_duty[c] == m_tgt[c]) begin
          m_move[c] = 0;
          m_done[c] = 1;
        end
      end
    end
  endfunction

  task automatic check_model(input string name);
    logic [8*NCH-1:0] xd;
    logic [NCH-1:0] xb;
    logic [NCH-1:0] xn;
    logic xt;
    for (int c = 0; c < NCH; c++) begin
      xd[8*c +: 8] = 8'(m_duty[c]);
      xb[c] = m_sweep[c] | m_move[c];
      xn[c] = m_done[c];
    end
    xt = (m_cnt == STEP - 1);
    vectors++;
    if (duty_out !== xd || busy !== xb || done !== xn
        || cmd_ready !== m_ready
        || dut.step_tick !== xt) begin
      miscompares++;
      $display("FAIL %s t=%0t: got duty=%h busy=%b done=%b rdy=%b tick=%b want duty=%h busy=%b done=%b rdy=%b tick=%b",
               name, $time, duty_out, busy, done, cmd_ready,
               dut.step_tick, xd, xb, xn, m_ready, xt);
    end
  endtask

  task automatic expect_eq(input string name, input int got,
                           input int want);
    vectors++;
    if (got != want) begin
      miscompares++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  task automatic cyc(input string name);
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_model(name);
  endtask

  function automatic int lane(input int c);
    return int'(duty_out[8*c +: 8]);
  endfunction

  task automatic wait_ticks(input int n, input string name);
    int base;
    int guard;
    base = m_ticks;
    guard = 0;
    while (m_ticks < base + n && guard < 3000) begin
      cyc(name);
      guard++;
    end
    if (m_ticks < base + n) expect_eq({name, "_timeout"}, 0, 1);
  endtask

  task automatic issue(input bit v, input int ch, input bit sw,
                       input int d);
    cmd_valid = v;
    cmd_ch = 3'(ch);
    cmd_sweep = sw;
    cmd_duty = 8'(d);
    cyc("cmd");
    cmd_valid = 1'b0;
  endtask

  typedef struct {
    bit valid;
    int ch;
    bit sweep;
    int duty;
    int ticks;
    int xch;
    int xduty;
    bit xbusy;
    bit xdone;
  } vec_t;

  vec_t tbl[10];

  initial begin
    int k;
    int prev;
    int guard;
    int pre2;

    tbl[0] = '{1, 0, 0, 40,  4, 0, 36, 1, 0};
    tbl[1] = '{0, 0, 0, 0,   4, 0, 40, 0, 1};
    tbl[2] = '{1, 1, 0, 60, 28, 1, 60, 0, 1};
    tbl[3] = '{1, 1, 0, 10, 14, 1, 46, 1, 0};
    tbl[4] = '{0, 0, 0, 0,  14, 1, 32, 0, 1};
    tbl[5] = '{1, 0, 0, 40,  0, 0, 40, 0, 1};
    tbl[6] = '{1, 5, 0, 60,  0, 0, 40, 0, 0};
    tbl[7] = '{1, 3, 0, 200, 32, 3, 64, 0, 1};
    tbl[8] = '{1, 2, 1, 0,  33, 2, 32, 1, 0};
    tbl[9] = '{0, 0, 0, 0,   1, 2, 33, 1, 0};

    model_reset();

    // Reset held three cycles.
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc("reset");
      expect_eq("rst_lane0", lane(0), 32);
      expect_eq("rst_lane3", lane(3), 32);
      expect_eq("rst_ready", int'(cmd_ready), 0);
      expect_eq("rst_busy", int'(busy), 0);
    end
    rst = 1'b0;
    cyc("release");
    expect_eq("ready_after_rst", int'(cmd_ready), 1);

    // Tick period.
    guard = 0;
    while (dut.step_tick !== 1'b1 && guard < 100) begin
      cyc("find_tick");
      guard++;
    end
    k = 0;
    do begin
      cyc("period");
      k++;
    end while (dut.step_tick !== 1'b1 && k < 100);
    expect_eq("tick_period", k, 20);

    // Table of commands with hand-derived results.
    foreach (tbl[i]) begin
      issue(tbl[i].valid, tbl[i].ch, tbl[i].sweep, tbl[i].duty);
      wait_ticks(tbl[i].ticks, "tbl_wait");
      expect_eq($sformatf("tbl%0d_duty", i),
                lane(tbl[i].xch), tbl[i].xduty);
      expect_eq($sformatf("tbl%0d_busy", i),
                int'(busy[tbl[i].xch]), int'(tbl[i].xbusy));
      expect_eq($sformatf("tbl%0d_done", i),
                int'(done[tbl[i].xch]), int'(tbl[i].xdone));
    end

    // Collision: command ch3 on a tick edge while sweeping at 45.
    issue(1, 3, 1, 0);
    guard = 0;
    while (!(m_duty[3] == 45 && m_cnt == STEP - 1)
           && guard < 3000) begin
      cyc("seek45");
      guard++;
    end
    expect_eq("seek45_found", m_duty[3], 45);
    pre2 = m_duty[2];
    issue(1, 3, 0, 50);
    expect_eq("coll_ch3_held", lane(3), 45);
    expect_eq("coll_ch3_busy", int'(busy[3]), 1);
    expect_eq("coll_ch2_step", lane(2),
              (pre2 == 64) ? 32 : pre2 + 1);
    wait_ticks(5, "coll_wait");
    expect_eq("coll_ch3_final", lane(3), 50);
    expect_eq("coll_ch3_done", int'(done[3]), 1);
    expect_eq("coll_ch3_idle", int'(busy[3]), 0);

    // Mid-ramp reset at 37.
    issue(1, 0, 0, 32);
    wait_ticks(8, "down32");
    expect_eq("ch0_at32", lane(0), 32);
    issue(1, 0, 0, 45);
    guard = 0;
    while (m_duty[0] != 37 && guard < 3000) begin
      cyc("seek37");
      guard++;
    end
    expect_eq("ch0_at37", lane(0), 37);
    rst = 1'b1;
    cyc("midrst");
    rst = 1'b0;
    for (int c = 0; c < NCH; c++)
      expect_eq("midrst_lane", lane(c), 32);
    expect_eq("midrst_busy", int'(busy), 0);
    expect_eq("midrst_ready", int'(cmd_ready), 0);
    k = 0;
    do begin
      cyc("post_rst");
      k++;
      if (k == 1) expect_eq("post_rst_ready", int'(cmd_ready), 1);
    end while (dut.step_tick !== 1'b1 && k < 100);
    expect_eq("post_rst_tick", k, 19);

    // Random commands, occasional reset.
    for (int i = 0; i < 3000; i++) begin
      cmd_valid = ($urandom_range(0, 7) == 0);
      cmd_ch = 3'($urandom_range(0, 5));
      cmd_sweep = ($urandom_range(0, 3) == 0);
      cmd_duty = 8'($urandom);
      rst = ($urandom_range(0, 699) == 0);
      cyc("rand");
    end
    rst = 1'b0;
    cmd_valid = 1'b0;
    prev = m_ticks;
    wait_ticks(2, "tail");
    expect_eq("tail_ticks", m_ticks - prev, 2);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
